// File: rtl/data_mem_lsu.sv
// Byte-addressed data memory with RISC-V load/store semantics in four byte-lane banks.
// Word-crossing accesses either take a second beat on the next word or are rejected with rsp_err.
module data_mem_lsu #(
    parameter int ADDR_W         = 12,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    typedef enum logic {IDLE, BEAT2} state_t;

    state_t state, state_nxt;

    function automatic logic [2:0] access_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    logic              accept;
    logic [2:0]        req_size;
    logic              bad_funct3;
    logic [ADDR_W:0]   req_last;
    logic              out_of_range;
    logic              crossing;
    logic              req_err;

    assign accept       = req_valid && req_ready;
    assign req_size     = access_size(req_funct3);
    assign bad_funct3   = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && req_funct3[1])
                          || (req_we && req_funct3[2]);
    // Last byte address with a carry bit, so running off the top of memory is visible.
    assign req_last     = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(req_size - 3'd1);
    assign out_of_range = (req_addr[31:ADDR_W] != '0) || req_last[ADDR_W];
    assign crossing     = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    assign req_err      = bad_funct3 || out_of_range || (crossing && !MISALIGN_SPLIT);

    logic [WORD_W-1:0] cap_word;
    logic [1:0]        cap_off;
    logic [2:0]        cap_f3;
    logic              cap_we;
    logic [31:0]       cap_wdata;

    always_comb begin
        state_nxt = state;
        req_ready = (state == IDLE);
        case (state)
            IDLE:    if (accept && !req_err && crossing) state_nxt = BEAT2;
            BEAT2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [WORD_W-1:0] cur_word;
    logic [1:0]        cur_off;
    logic [2:0]        cur_size;
    logic              cur_we;
    logic [31:0]       cur_wdata;
    logic              cur_active;
    logic              cur_beat2;

    // Second beat replays the captured request against the following word.
    always_comb begin
        cur_word   = req_addr[ADDR_W-1:2];
        cur_off    = req_addr[1:0];
        cur_size   = req_size;
        cur_we     = req_we;
        cur_wdata  = req_wdata;
        cur_active = accept && !req_err;
        cur_beat2  = 1'b0;
        if (state == BEAT2) begin
            cur_word   = cap_word + WORD_W'(1);
            cur_off    = cap_off;
            cur_size   = access_size(cap_f3);
            cur_we     = cap_we;
            cur_wdata  = cap_wdata;
            cur_active = 1'b1;
            cur_beat2  = 1'b1;
        end
    end

    logic [3:0][7:0] lane_rd;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        localparam logic [1:0] LANE = 2'(l);
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;
        logic [1:0] k;
        logic       en;

        // Byte k of the access lives in lane (offset + k) mod 4 in both beats.
        assign k  = LANE - cur_off;
        assign en = cur_active && ({1'b0, k} < cur_size)
                    && (cur_beat2 ? (LANE < cur_off) : (LANE >= cur_off));

        always_ff @(posedge clk) begin
            if (en) begin
                if (cur_we) mem[cur_word] <= cur_wdata[{k, 3'b000} +: 8];
                else        rd_q          <= mem[cur_word];
            end
        end

        assign lane_rd[l] = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            cap_word  <= '0;
            cap_off   <= '0;
            cap_f3    <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= (state == BEAT2) || (accept && (req_err || !crossing));
            rsp_err   <= accept && req_err;
            if (accept) begin
                cap_word  <= req_addr[ADDR_W-1:2];
                cap_off   <= req_addr[1:0];
                cap_f3    <= req_funct3;
                cap_we    <= req_we;
                cap_wdata <= req_wdata;
            end
        end
    end

    logic [31:0] assembled;

    // Lane registers hold the beat-1 bytes untouched while beat 2 fills the low lanes.
    always_comb begin
        assembled = '0;
        for (int i = 0; i < 4; i++) assembled[8*i +: 8] = lane_rd[2'(i) + cap_off];
        rsp_rdata = '0;
        if (rsp_valid && !rsp_err && !cap_we) begin
            case (cap_f3)
                3'd0:    rsp_rdata = {{24{assembled[7]}}, assembled[7:0]};
                3'd1:    rsp_rdata = {{16{assembled[15]}}, assembled[15:0]};
                3'd2:    rsp_rdata = assembled;
                3'd4:    rsp_rdata = {24'd0, assembled[7:0]};
                3'd5:    rsp_rdata = {16'd0, assembled[15:0]};
                default: rsp_rdata = '0;
            endcase
        end
    end

endmodule
